// File: rtl/energy_pkg.sv
// Shared types and constants for the sliding-window energy controller.
package energy_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun
  } state_e;

  localparam int unsigned DefaultSampleW = 16;
  localparam int unsigned DefaultEnergyW = 64;

  // Bits needed to count 0..window_size inclusive.
  function automatic int unsigned fill_count_w(input int unsigned window_size);
    return $clog2(window_size + 1);
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Circular sample history: one write port, one read at the write pointer.
// The read returns the entry about to be overwritten (read-before-write).
module sample_ring_buffer #(
  parameter int unsigned DEPTH = 15,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;

  assign rdata = mem_q[wptr_q];

  // Pointer advance with wrap at DEPTH-1; clear restarts at slot 0.
  always_comb begin
    wptr_d = wptr_q;
    if (clear) begin
      wptr_d = '0;
    end else if (write) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    end
  end

  // Write pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  // Storage is not reset; slots above the fill level are never used as history.
  always_ff @(posedge clock) begin
    if (write) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/energy_window_ctrl.sv
// Sequencing controller for the sliding-window signal-energy datapath.
// Holds the sample history, feeds entering/leaving samples with an update
// strobe, aligns returned energy and runs a hysteresis activity detect.
// Optional statistics (detect_events, peak_energy) with ENERGY_WIN_STATS_EN.
module energy_window_ctrl
  import energy_pkg::*;
#(
  parameter int unsigned WINDOW_SIZE = 15,
  parameter int unsigned SAMPLE_W    = DefaultSampleW,
  parameter int unsigned ENERGY_W    = DefaultEnergyW,
  parameter int unsigned DP_LATENCY  = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  clear,
  input  logic signed [SAMPLE_W-1:0]            sample_in,
  input  logic                                  sample_valid,
  output logic                                  sample_ready,
  output logic signed [SAMPLE_W-1:0]            first,
  output logic signed [SAMPLE_W-1:0]            last,
  output logic                                  update,
  output logic                                  dp_clear,
  input  logic signed [ENERGY_W-1:0]            energy_in,
  input  logic signed [ENERGY_W-1:0]            thresh_hi,
  input  logic signed [ENERGY_W-1:0]            thresh_lo,
  output logic                                  energy_valid,
  output logic                                  window_full,
  output logic [fill_count_w(WINDOW_SIZE)-1:0]  fill_count,
  output logic                                  detect
`ifdef ENERGY_WIN_STATS_EN
  ,
  output logic [15:0]                           detect_events,
  output logic signed [ENERGY_W-1:0]            peak_energy
`endif
);

  localparam int unsigned FillW = fill_count_w(WINDOW_SIZE);
  localparam logic [FillW-1:0] FullCount = FillW'(WINDOW_SIZE);
  localparam logic [FillW-1:0] LastCount = FillW'(WINDOW_SIZE - 1);

  state_e                     state_q, state_d;
  logic signed [SAMPLE_W-1:0] first_q, first_d;
  logic signed [SAMPLE_W-1:0] last_q, last_d;
  logic                       update_q, update_d;
  logic                       dp_clear_q;
  logic [FillW-1:0]           fill_q, fill_d;
  logic [DP_LATENCY-1:0]      vpipe_q, vpipe_d;
  logic                       detect_q, detect_d;
  logic                       accept;
  logic                       full;
  logic                       ev;
  logic [SAMPLE_W-1:0]        ring_rdata;

  assign full         = (fill_q == FullCount);
  assign ev           = vpipe_q[DP_LATENCY-1];
  assign sample_ready = (state_q != StIdle) && !clear;
  assign accept       = sample_valid && sample_ready;

  assign first        = first_q;
  assign last         = last_q;
  assign update       = update_q;
  assign dp_clear     = dp_clear_q;
  assign energy_valid = ev;
  assign window_full  = full;
  assign fill_count   = fill_q;
  assign detect       = detect_q;

  sample_ring_buffer #(
    .DEPTH (WINDOW_SIZE),
    .WIDTH (SAMPLE_W)
  ) u_ring (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .write (accept),
    .wdata (sample_in),
    .rdata (ring_rdata)
  );

  // Next state: enable low parks in idle; restart resumes by fill level.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else if (clear) begin
      state_d = StFill;
    end else begin
      unique case (state_q)
        StIdle:  state_d = full ? StRun : StFill;
        StFill:  if (accept && fill_q == LastCount) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Sample hand-off, fill level, valid alignment pipe and hysteresis detect.
  always_comb begin
    first_d  = first_q;
    last_d   = last_q;
    update_d = 1'b0;
    fill_d   = fill_q;
    vpipe_d  = (vpipe_q << 1) | DP_LATENCY'(update_q);
    detect_d = detect_q;
    if (clear) begin
      first_d  = '0;
      last_d   = '0;
      fill_d   = '0;
      vpipe_d  = '0;
      detect_d = 1'b0;
    end else begin
      if (accept) begin
        first_d  = sample_in;
        // Until the window is full there is no leaving sample.
        last_d   = full ? ring_rdata : '0;
        update_d = 1'b1;
        if (!full) fill_d = fill_q + 1'b1;
      end
      // Set wins over release if the thresholds are misconfigured.
      if (ev && full) begin
        if (energy_in > thresh_hi) begin
          detect_d = 1'b1;
        end else if (energy_in < thresh_lo) begin
          detect_d = 1'b0;
        end
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      first_q    <= '0;
      last_q     <= '0;
      update_q   <= 1'b0;
      dp_clear_q <= 1'b0;
      fill_q     <= '0;
      vpipe_q    <= '0;
      detect_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      last_q     <= last_d;
      update_q   <= update_d;
      dp_clear_q <= clear;
      fill_q     <= fill_d;
      vpipe_q    <= vpipe_d;
      detect_q   <= detect_d;
    end
  end

`ifdef ENERGY_WIN_STATS_EN
  logic [15:0]                events_q, events_d;
  logic signed [ENERGY_W-1:0] peak_q, peak_d;

  assign detect_events = events_q;
  assign peak_energy   = peak_q;

  // Saturating rising-edge counter and running maximum of full-window energy.
  always_comb begin
    events_d = events_q;
    peak_d   = peak_q;
    if (clear) begin
      events_d = '0;
      peak_d   = '0;
    end else begin
      if (detect_d && !detect_q && events_q != 16'hFFFF) events_d = events_q + 16'd1;
      if (ev && full && energy_in > peak_q) peak_d = energy_in;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      events_q <= '0;
      peak_q   <= '0;
    end else begin
      events_q <= events_d;
      peak_q   <= peak_d;
    end
  end
`else
  // Statistics disabled: no counter or peak tracker exists.
`endif

endmodule

// File: tb/tb_energy_window_ctrl.sv
// Directed bench for energy_window_ctrl with a behavioural energy datapath.
module tb_energy_window_ctrl;

  localparam int unsigned WS = 4;
  localparam int unsigned SW = 16;
  localparam int unsigned EW = 64;
  localparam int unsigned DL = 2;
  localparam int unsigned FW = $clog2(WS + 1);

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 clear;
  logic signed [SW-1:0] sample_in;
  logic                 sample_valid;
  logic                 sample_ready;
  logic signed [SW-1:0] first;
  logic signed [SW-1:0] last;
  logic                 update;
  logic                 dp_clear;
  logic signed [EW-1:0] energy_in;
  logic signed [EW-1:0] thresh_hi;
  logic signed [EW-1:0] thresh_lo;
  logic                 energy_valid;
  logic                 window_full;
  logic [FW-1:0]        fill_count;
  logic                 detect;
`ifdef ENERGY_WIN_STATS_EN
  logic [15:0]          detect_events;
  logic signed [EW-1:0] peak_energy;
`endif

  int checks = 0;
  int errors = 0;

  logic                 mon_en = 1'b0;
  int                   upd_cnt = 0;
  logic signed [SW-1:0] seen_first[$];
  logic signed [SW-1:0] seen_last[$];
  logic signed [EW-1:0] acc;

  int exp_slide_last[6] = '{0, 0, 0, 0, 1, 2};
  int exp_gap_first[4]  = '{10, 12, 14, 15};
  int exp_gap_last[4]   = '{3, 4, 5, 6};

  energy_window_ctrl #(
    .WINDOW_SIZE (WS),
    .SAMPLE_W    (SW),
    .ENERGY_W    (EW),
    .DP_LATENCY  (DL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .first         (first),
    .last          (last),
    .update        (update),
    .dp_clear      (dp_clear),
    .energy_in     (energy_in),
    .thresh_hi     (thresh_hi),
    .thresh_lo     (thresh_lo),
    .energy_valid  (energy_valid),
    .window_full   (window_full),
    .fill_count    (fill_count),
    .detect        (detect)
`ifdef ENERGY_WIN_STATS_EN
    ,
    .detect_events (detect_events),
    .peak_energy   (peak_energy)
`endif
  );

  always #5 clock = ~clock;

  // Energy datapath: two-stage, so energy_in reflects an update two cycles later.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      energy_in <= '0;
    end else if (dp_clear) begin
      acc       <= '0;
      energy_in <= '0;
    end else begin
      if (update) begin
        acc <= acc + longint'(first) * longint'(first) - longint'(last) * longint'(last);
      end
      energy_in <= acc;
    end
  end

  // Record every update pulse once (each pulse spans exactly one negedge).
  always @(negedge clock) begin
    if (mon_en && update) begin
      upd_cnt++;
      seen_first.push_back(first);
      seen_last.push_back(last);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle, then idle until its energy has landed.
  task automatic push(input int x);
    sample_valid = 1'b1;
    sample_in    = SW'(x);
    @(negedge clock);
    sample_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    clear        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    thresh_hi    = 64'sd1000;
    thresh_lo    = 64'sd0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_ready", sample_ready, 0);
    chk("rst_first", first, 0);
    chk("rst_last", last, 0);
    chk("rst_update", update, 0);
    chk("rst_dp_clear", dp_clear, 0);
    chk("rst_ev", energy_valid, 0);
    chk("rst_full", window_full, 0);
    chk("rst_fill", fill_count, 0);
    chk("rst_detect", detect, 0);
`ifdef ENERGY_WIN_STATS_EN
    chk("rst_events", detect_events, 0);
    chk("rst_peak", peak_energy, 0);
`endif
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", sample_ready, 0);
    enable = 1'b1;
    @(negedge clock);
    chk("fill_ready", sample_ready, 1);

    // Fill then slide: 1..6 back-to-back
    sample_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      sample_in = SW'(i);
      @(negedge clock);
      chk($sformatf("slide_first%0d", i), first, i);
      chk($sformatf("slide_last%0d", i), last, exp_slide_last[i-1]);
      chk($sformatf("slide_update%0d", i), update, 1);
      chk($sformatf("slide_fill%0d", i), fill_count, (i < 4) ? i : 4);
      chk($sformatf("slide_full%0d", i), window_full, (i >= 4) ? 1 : 0);
    end
    sample_valid = 1'b0;
    @(negedge clock);
    chk("slide_ev5", energy_valid, 1);
    chk("slide_energy5", energy_in, 54);
    @(negedge clock);
    chk("slide_ev6", energy_valid, 1);
    chk("slide_energy6", energy_in, 86);
    @(negedge clock);
    chk("slide_ev_end", energy_valid, 0);
    chk("slide_update_end", update, 0);
    chk("slide_first_hold", first, 6);
    chk("slide_last_hold", last, 2);

    // Gaps and enable dropped mid-stream
    mon_en       = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'sd10;
    @(negedge clock);
    sample_valid = 1'b0;
    sample_in    = 16'sd11;
    @(negedge clock);
    sample_valid = 1'b1;
    sample_in    = 16'sd12;
    enable       = 1'b0;
    #1 chk("gap_ready_drop", sample_ready, 1);
    @(negedge clock);
    sample_valid = 1'b0;
    @(negedge clock);
    sample_valid = 1'b1;
    sample_in    = 16'sd14;
    #1 chk("gap_ready_idle", sample_ready, 0);
    @(negedge clock);
    enable = 1'b1;
    #1 chk("gap_ready_reen", sample_ready, 0);
    @(negedge clock);
    #1 chk("gap_ready_run", sample_ready, 1);
    @(negedge clock);
    sample_valid = 1'b0;
    @(negedge clock);
    sample_valid = 1'b1;
    sample_in    = 16'sd15;
    @(negedge clock);
    sample_valid = 1'b0;
    repeat (3) @(negedge clock);
    mon_en = 1'b0;
    chk("gap_update_count", upd_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gap_first%0d", i), seen_first[i], exp_gap_first[i]);
      chk($sformatf("gap_last%0d", i), seen_last[i], exp_gap_last[i]);
    end
    chk("gap_energy", energy_in, 665);
    chk("gap_detect", detect, 0);

    // Hysteresis
    thresh_hi = 64'sd100;
    thresh_lo = 64'sd40;
    repeat (4) push(8);
    chk("hyst_energy256", energy_in, 256);
    chk("hyst_set", detect, 1);
    repeat (3) push(3);
    chk("hyst_energy91", energy_in, 91);
    chk("hyst_hold1", detect, 1);
    push(3);
    chk("hyst_energy36", energy_in, 36);
    chk("hyst_release", detect, 0);
    push(7);
    push(1);
    push(1);
    chk("hyst_energy60", energy_in, 60);
    chk("hyst_hold0", detect, 0);
    push(10);
    chk("hyst_energy151", energy_in, 151);
    chk("hyst_reset", detect, 1);

    // Clear mid-run with a sample offered in the same cycle
    clear        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'sd99;
    #1 chk("clr_ready", sample_ready, 0);
    @(negedge clock);
    clear        = 1'b0;
    sample_valid = 1'b0;
    chk("clr_dp_clear", dp_clear, 1);
    chk("clr_fill", fill_count, 0);
    chk("clr_full", window_full, 0);
    chk("clr_detect", detect, 0);
    chk("clr_update", update, 0);
    chk("clr_first", first, 0);
    chk("clr_last", last, 0);
    @(negedge clock);
    chk("clr_dp_clear_end", dp_clear, 0);
    chk("clr_ready_after", sample_ready, 1);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in    = SW'(20 + i);
      @(negedge clock);
      chk($sformatf("clr_first%0d", i), first, 20 + i);
      chk($sformatf("clr_last%0d", i), last, 0);
      chk($sformatf("clr_fill%0d", i), fill_count, i + 1);
    end
    sample_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("clr_energy", energy_in, 1854);
    chk("clr_detect_again", detect, 1);

    // Async reset between an update and its energy_valid
    sample_valid = 1'b1;
    sample_in    = 16'sd5;
    @(negedge clock);
    sample_valid = 1'b0;
    chk("arst_update_before", update, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_update", update, 0);
    chk("arst_first", first, 0);
    chk("arst_last", last, 0);
    chk("arst_fill", fill_count, 0);
    chk("arst_detect", detect, 0);
    chk("arst_ev", energy_valid, 0);
    chk("arst_ready", sample_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("arst_no_ev%0d", i), energy_valid, 0);
    end

`ifdef ENERGY_WIN_STATS_EN
    // Statistics: three detect rising edges, peak 400
    repeat (4) push(10);
    repeat (4) push(0);
    push(6);
    push(11);
    repeat (4) push(0);
    push(12);
    chk("stats_detect", detect, 1);
    chk("stats_events", detect_events, 3);
    chk("stats_peak", peak_energy, 400);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("stats_events_clr", detect_events, 0);
    chk("stats_peak_clr", peak_energy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/energy_window_ctrl.md
Name: energy_window_ctrl

Overview:
- Sequencing controller for the sliding-window signal-energy datapath.
- Owns the WINDOW_SIZE-deep circular sample history and accepts samples over a valid/ready handshake.
- Per accepted sample, drives the datapath with the entering sample (first), the leaving sample (last) and a one-cycle update pulse.
- Aligns the returned energy to the datapath latency and produces a hysteresis-based activity detect.

Parameters:
- WINDOW_SIZE, 15: samples in the energy window; legal range ≥2.
- SAMPLE_W, 16: signed sample width.
- ENERGY_W, 64: signed energy width.
- DP_LATENCY, 2: cycles from the update pulse until energy_in reflects that update.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; low holds the block in IDLE.
- clear  in  1  synchronous one-cycle restart of the window.
- sample_in  in  SAMPLE_W  signed incoming sample.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  controller can accept a sample.
- first  out  SAMPLE_W  entering sample to the datapath.
- last  out  SAMPLE_W  leaving sample to the datapath.
- update  out  1  one-cycle datapath update strobe.
- dp_clear  out  1  drives the datapath's synchronous reset.
- energy_in  in  ENERGY_W  energy returned by the datapath.
- thresh_hi  in  ENERGY_W  detect assert level.
- thresh_lo  in  ENERGY_W  detect release level.
- energy_valid  out  1  energy_in is aligned to the latest update.
- window_full  out  1  WINDOW_SIZE samples are held.
- fill_count  out  $clog2(WINDOW_SIZE+1)  samples held, 0..WINDOW_SIZE.
- detect  out  1  activity flag.

Behaviour:
- Reset (async) values: all outputs 0; state IDLE; write pointer 0; buffer contents don't-care (masked by fill_count).
- States:
  - IDLE → FILL when enable=1.
  - FILL → RUN on the accept that makes fill_count = WINDOW_SIZE.
  - RUN stays in RUN.
  - Any state → IDLE when enable=0 (takes effect next cycle; history retained, restart resumes in the state implied by fill_count).
- Handshake:
  - sample_ready = (state≠IDLE) && !clear; combinational.
  - Accept = sample_valid && sample_ready. No throughput limit: one accept per cycle sustained.
- On an accept in cycle N, registered at edge N+1:
  - first ← sample_in.
  - last ← buf[wptr] if fill_count = WINDOW_SIZE, else 0.
  - update ← 1.
  - buf[wptr] ← sample_in.
  - wptr ← (wptr = WINDOW_SIZE−1) ? 0 : wptr+1.
  - fill_count saturates at WINDOW_SIZE.
- Non-accept cycle: update ← 0; first/last hold their values.
- energy_valid pulses one cycle, DP_LATENCY cycles after the update pulse. Implemented as a shift register, so back-to-back updates produce back-to-back valids.
- Detect, evaluated only on energy_valid && window_full, signed compare:
  - Set when energy_in > thresh_hi.
  - Cleared when energy_in < thresh_lo.
  - Otherwise held.
  - thresh_lo > thresh_hi is a configuration error; set has priority.
- clear:
  - dp_clear=1 for the following cycle.
  - wptr, fill_count, detect, first, last, update and the energy_valid pipeline → 0.
  - State → FILL (IDLE if enable=0).
  - A sample presented during clear is not accepted (ready low).
- Async reset mid-operation: immediate return to reset values; any in-flight energy_valid is lost.

Optional Feature:
- Macro: ENERGY_WIN_STATS_EN.
- Defined:
  - Adds output detect_events (16 bits), reset 0.
  - Increments on each 0→1 detect transition, saturates at 0xFFFF.
  - Cleared by reset and by clear.
  - Adds output peak_energy (ENERGY_W): maximum energy_in seen on energy_valid while window_full; cleared likewise.
- Undefined: neither port exists; no added logic.

Decomposition:
- Package energy_pkg:
  - state enum (IDLE, FILL, RUN);
  - default SAMPLE_W / ENERGY_W constants;
  - fill-count width function.
- Sub-module sample_ring_buffer:
  - parameterised depth/width;
  - one write port and one read at the write pointer (read-before-write in the same cycle);
  - owns wptr wrap.

Test Plan (WINDOW_SIZE=4, DP_LATENCY=2, behavioural model of the energy datapath in the bench):
- Fill then slide: accept 1,2,3,4,5,6 back-to-back → last = 0,0,0,0,1,2; window_full rises on the 4th accept's edge; modelled energy after 6th = 3²+4²+5²+6² = 86.
- Backpressure/gaps: valid toggling 1,0,1,0 with enable pulled low mid-stream → no accept while ready=0; update count equals accept count; no sample lost or duplicated.
- Hysteresis: thresh_hi=100, thresh_lo=40, window of 8s (256) → detect=1; then 3s (36) → detect=0; energy 60 → detect holds its value.
- Clear mid-RUN with sample_valid=1 in the same cycle:
  - sample not accepted; dp_clear pulses;
  - fill_count=0, detect=0;
  - the next 4 samples produce last=0.
- Async reset asserted between an update and its energy_valid → outputs 0 immediately; no energy_valid pulse emitted afterwards.
- ENERGY_WIN_STATS_EN: three detect rising edges → detect_events=3; peak_energy equals the largest windowed energy; both cleared by clear.
